// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmitter, one 8-bit word per frame.
// Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
// Each bit is held for P clocks; P is the prescale latched at acceptance,
// with 0 treated as 1.
// Ports:
//   clk        system clock, rising edge
//   rest       asynchronous active-high reset
//   p_data     word to transmit
//   data_valid send request; only honoured in IDLE
//   par_en     1 = append parity bit
//   par_typ    0 = even, 1 = odd parity
//   prescale   clocks per bit (0 -> 1)
//   tx_out     serial line, idles at 1 (registered)
//   busy       frame in progress (registered)
//   tx_done    one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_frame #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [DATA_W-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [4:0]        prescale,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [4:0]        cnt, cnt_n;     // bit-time edge counter, runs 1..P
  logic [2:0]        idx, idx_n;     // data bit index
  logic [DATA_W-1:0] data_r;
  logic              par_en_r, par_typ_r;
  logic [4:0]        p_r;
  logic              load;
  logic              tx_n, busy_n, done_n;
  logic              par_bit;

  assign par_bit = (^data_r) ^ par_typ_r;

  // Outputs are computed from the next state so that they can be
  // registered without adding a cycle of latency to the line.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    load    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          load    = 1'b1;
          state_n = START;
          cnt_n   = 5'd1;
          idx_n   = 3'd0;
        end
      end
      default: begin
        if (cnt == p_r) begin
          cnt_n = 5'd1;
          case (state)
            START: begin
              state_n = DATA;
              idx_n   = 3'd0;
            end
            DATA: begin
              if (idx == 3'(DATA_W - 1)) state_n = par_en_r ? PARITY : STOP;
              else                       idx_n   = idx + 3'd1;
            end
            PARITY: state_n = STOP;
            STOP: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
    endcase

    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_r[idx_n];
      PARITY:  tx_n = par_bit;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      idx       <= 3'd0;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      p_r       <= 5'd0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      tx_out  <= tx_n;
      busy    <= busy_n;
      tx_done <= done_n;
      if (load) begin
        data_r    <= p_data;
        par_en_r  <= par_en;
        par_typ_r <= par_typ;
        p_r       <= (prescale == 5'd0) ? 5'd1 : prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Expected line waveforms are
// built from the frame definition (bit list x bit time), not from the
// block's internal state.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rest;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [4:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int errs    = 0;

  uart_tx_frame #(.DATA_W(8)) dut (
    .clk        (clk),
    .rest       (rest),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input logic done_exp);
    chk({tag, ".tx"},   tx_out,  1'b1);
    chk({tag, ".busy"}, busy,    1'b0);
    chk({tag, ".done"}, tx_done, done_exp);
  endtask

  // Called at a negedge. Presents a request, then checks every cycle of the
  // frame plus the tx_done cycle. junk: scramble inputs (incl. data_valid
  // pulses) during the frame. next_valid: data_valid level left on the line
  // in the tx_done cycle. abort_at: frame cycle at which reset is asserted
  // (-1 = none); the task returns after reset is released.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [4:0] ps, input bit junk,
                           input bit next_valid, input int abort_at);
    logic bits[11];
    int   nb, p;
    p_data = d; par_en = pe; par_typ = pt; prescale = ps; data_valid = 1'b1;
    p  = (ps == 0) ? 1 : int'(ps);
    nb = pe ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = pe ? ((^d) ^ pt) : 1'b1;
    bits[10] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    for (int k = 0; k < nb * p; k++) begin
      chk($sformatf("frm%02h.bit%0d.tx", d, k / p), tx_out, bits[k / p]);
      chk("frm.busy", busy, 1'b1);
      chk("frm.done", tx_done, 1'b0);
      if (k == abort_at) begin
        rest = 1'b1;
        #1;
        chk_idle("rst.async", 1'b0);
        @(negedge clk);
        chk_idle("rst.hold", 1'b0);
        rest = 1'b0;
        for (int j = 0; j < 3 * p; j++) begin
          @(negedge clk);
          chk_idle("rst.after", 1'b0);
        end
        return;
      end
      if (junk && k < nb * p - 1) begin
        p_data     = 8'($urandom);
        par_en     = 1'($urandom);
        par_typ    = 1'($urandom);
        prescale   = 5'($urandom);
        data_valid = 1'($urandom);
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk_idle("frm.end", 1'b1);
    data_valid = next_valid;
  endtask

  initial begin
    rest = 1'b1; p_data = 8'h00; data_valid = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; prescale = 5'd0;
    #1;
    chk_idle("reset", 1'b0);
    repeat (2) @(negedge clk);
    chk_idle("reset.hold", 1'b0);
    rest = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("idle", 1'b0);
    end

    // Directed frames
    run_frame(8'hA5, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, -1);
    @(negedge clk); chk_idle("gap", 1'b0);
    run_frame(8'h01, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, -1);
    run_frame(8'h03, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, -1);
    @(negedge clk); chk_idle("gap", 1'b0);
    run_frame(8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, -1);
    @(negedge clk); chk_idle("gap", 1'b0);

    // data_valid held high: back-to-back frames one idle cycle apart
    run_frame(8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, -1);
    run_frame(8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, -1);
    run_frame(8'h5A, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, -1);
    @(negedge clk); chk_idle("gap", 1'b0);

    // Inputs scrambled mid-frame must not disturb the frame
    run_frame(8'hC3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_idle("no2nd", 1'b0);
    end

    // Reset during DATA bit 3 of a P=4 frame: (1 start + 3 data) * 4 + 1
    run_frame(8'h96, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 17);
    run_frame(8'h96, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, -1);
    @(negedge clk); chk_idle("gap", 1'b0);

    // Reset on the same edge as a request: nothing accepted
    data_valid = 1'b1; p_data = 8'h00; rest = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk_idle("rst.vs.req", 1'b0);
    rest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_idle("rst.vs.req.after", 1'b0);
    end

    // Randomized frames
    for (int n = 0; n < 25; n++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 6)), 1'($urandom), 1'b0, -1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); chk_idle("rgap", 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
